keypad_fifo_ctrl: RTL and testbench



---
 rtl/keypad_fifo_ctrl.sv | 155 +++++++++++++++
 tb/tb_keypad_fifo_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_fifo_ctrl
//  Purpose  : Autonomous keypad handshake sequencer with a small key-code
//             FIFO exposed to the CPU as a status and a data register.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_fifo_ctrl #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] CHK_ADDR = 16'h03F0,
    parameter logic [15:0] DAT_ADDR = 16'h03F1
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [15:0] kp_keyout,
    output logic        kp_statusordata,
    output logic        kp_ack,
    input  logic [15:0] cpu_address,
    input  logic        cpu_rd,
    output logic        cpu_hit,
    output logic [15:0] cpu_rd_data
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_POLL  = 2'd0,
        S_FETCH = 2'd1,
        S_ACK   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_cnt5;
    logic            w_unused_bits;

    // Full/empty come from the registered count, so a pop in a POLL cycle
    // only unblocks the keypad on the following cycle.
    assign w_full  = (count_q == FULL_CNT);
    assign w_empty = (count_q == '0);
    assign w_cnt5  = 5'(count_q);

    // A reset in the FETCH cycle must not capture the key.
    assign w_push  = (state_q == S_FETCH) && !rst;
    assign w_pop   = cpu_rd && (cpu_address == DAT_ADDR) && !w_empty;

    // Upper keypad bits and the top count bit are intentionally ignored.
    assign w_unused_bits = ^{kp_keyout[15:4], w_cnt5[4]};

    // Keypad handshake state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_POLL;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake next state and keypad-side outputs.
    always_comb begin
        state_d         = state_q;
        kp_statusordata = 1'b1;
        kp_ack          = 1'b0;
        case (state_q)
            S_POLL: begin
                if (kp_keyout[0] && !w_full) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                kp_statusordata = 1'b0;
                state_d         = S_ACK;
            end
            S_ACK: begin
                kp_statusordata = 1'b0;
                // Suppressed under reset so the keypad keeps its key.
                kp_ack          = !rst;
                state_d         = S_GAP;
            end
            S_GAP: begin
                state_d = S_POLL;
            end
            default: begin
                state_d = S_POLL;
            end
        endcase
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Key-code storage; contents need no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= kp_keyout[3:0];
        end
    end

    // CPU register decode and read data, no added latency.
    always_comb begin
        cpu_hit     = 1'b0;
        cpu_rd_data = 16'h0000;
        if (cpu_address == CHK_ADDR) begin
            cpu_hit     = 1'b1;
            cpu_rd_data = {8'h00, w_cnt5[3:0], 2'b00, w_full, ~w_empty};
        end else if (cpu_address == DAT_ADDR) begin
            cpu_hit = 1'b1;
            if (!w_empty) begin
                cpu_rd_data = {12'h000, mem_q[rd_ptr_q]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_fifo_ctrl
//  Purpose  : Self-checking bench for keypad_fifo_ctrl with a keypad model
//             and a queue-based FIFO reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_fifo_ctrl;

    localparam int          DEPTH = 8;
    localparam logic [15:0] CHK   = 16'h03F0;
    localparam logic [15:0] DAT   = 16'h03F1;

    logic        CLK = 1'b0;
    logic        rst;
    logic [15:0] kp_keyout;
    logic        kp_statusordata;
    logic        kp_ack;
    logic [15:0] cpu_address;
    logic        cpu_rd;
    logic        cpu_hit;
    logic [15:0] cpu_rd_data;

    keypad_fifo_ctrl #(.DEPTH(DEPTH), .CHK_ADDR(CHK), .DAT_ADDR(DAT)) dut (
        .CLK             (CLK),
        .rst             (rst),
        .kp_keyout       (kp_keyout),
        .kp_statusordata (kp_statusordata),
        .kp_ack          (kp_ack),
        .cpu_address     (cpu_address),
        .cpu_rd          (cpu_rd),
        .cpu_hit         (cpu_hit),
        .cpu_rd_data     (cpu_rd_data)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- keypad model ----------------
    logic       kp_pending = 1'b0;
    logic [3:0] kp_code    = 4'h0;
    logic [3:0] kp_src[$];
    int         ack_count  = 0;
    logic       ack_seen;

    assign kp_keyout = kp_statusordata ? {15'h0000, kp_pending} : {12'h000, kp_code};

    // Keypad: ack consumes the key; next queued key is presented a cycle later.
    always begin
        @(negedge CLK); #2;
        ack_seen = kp_ack;
        @(posedge CLK); #1;
        if (ack_seen) begin
            kp_pending = 1'b0;
            ack_count++;
        end else if (!kp_pending && kp_src.size() > 0) begin
            kp_code    = kp_src.pop_front();
            kp_pending = 1'b1;
        end
    end

    // ---------------- reference FIFO + protocol monitor ----------------
    logic [3:0] mq[$];
    logic       mon_en     = 1'b0;
    logic       prev_fetch = 1'b0;
    int         n_pop      = 0;

    always begin
        @(negedge CLK); #2;
        if (mon_en) begin
            logic        fetch;
            logic        pop;
            logic [15:0] exp_data;
            int          cnt;
            cnt      = mq.size();
            exp_data = 16'h0000;
            if (cpu_address == CHK)
                exp_data = {8'h00, 4'(cnt), 2'b00, (cnt == DEPTH), (cnt != 0)};
            else if (cpu_address == DAT && cnt > 0)
                exp_data = {12'h000, mq[0]};
            chk("mon_hit", 16'(cpu_hit), 16'((cpu_address == CHK) || (cpu_address == DAT)));
            chk("mon_rdata", cpu_rd_data, exp_data);
            chk("mon_ack_in_status_view", 16'(kp_ack & kp_statusordata), 16'h0000);
            chk("mon_ack_follows_fetch", 16'(kp_ack), 16'(prev_fetch && !rst));
            fetch = !kp_statusordata && !kp_ack && !rst;
            pop   = cpu_rd && (cpu_address == DAT) && (cnt > 0) && !rst;
            if (fetch)
                chk("mon_fetch_not_full", 16'(cnt < DEPTH), 16'h0001);
            if (rst) begin
                mq.delete();
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    n_pop++;
                end
                if (fetch)
                    mq.push_back(kp_code);
            end
            prev_fetch = fetch;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK); #2;
    endtask

    // Called at posedge+2; returns at posedge+2 of the next cycle.
    task automatic rd_chk(input string nm, input logic [15:0] a, input logic r,
                          input logic [15:0] exp);
        cpu_address = a;
        cpu_rd      = r;
        @(negedge CLK); #1;
        chk(nm, cpu_rd_data, exp);
        tick();
        cpu_rd      = 1'b0;
        cpu_address = 16'h0000;
    endtask

    task automatic wait_acks(input int target, input string nm);
        int k = 0;
        while (ack_count < target && k < 300) begin
            tick();
            k++;
        end
        chk(nm, 16'(ack_count >= target), 16'h0001);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        hit;
        logic [15:0] data;
    } vec_t;
    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  lat;
        int  found;
        int  offered;
        int  pop0;
        int  k;

        // FIFO holds {7, A} when the table starts.
        tbl[0] = '{CHK,      1'b0, 1'b1, 16'h0021};
        tbl[1] = '{DAT,      1'b0, 1'b1, 16'h0007};
        tbl[2] = '{16'h03F2, 1'b1, 1'b0, 16'h0000};
        tbl[3] = '{16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{CHK,      1'b0, 1'b1, 16'h0021};
        tbl[5] = '{DAT,      1'b1, 1'b1, 16'h0007};
        tbl[6] = '{DAT,      1'b1, 1'b1, 16'h000A};
        tbl[7] = '{DAT,      1'b1, 1'b1, 16'h0000};
        tbl[8] = '{CHK,      1'b0, 1'b1, 16'h0000};
        tbl[9] = '{16'h13F0, 1'b0, 1'b0, 16'h0000};

        rst = 1'b1; cpu_address = 16'h0000; cpu_rd = 1'b0;
        @(posedge CLK); #2;
        mon_en = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset then idle.
        cpu_address = CHK;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1;
            chk("idle_sod", 16'(kp_statusordata), 16'h0001);
            chk("idle_ack", 16'(kp_ack), 16'h0000);
            chk("idle_chk", cpu_rd_data, 16'h0000);
        end
        tick();

        // Single key with ack latency.
        kp_src.push_back(4'h7);
        lat = 0;
        while (!kp_ack && lat < 20) begin
            tick();
            lat++;
        end
        chk("single_ack_latency", 16'(lat), 16'd3);
        tick(); tick();
        rd_chk("single_chk", CHK, 1'b0, 16'h0011);
        rd_chk("single_dat", DAT, 1'b1, 16'h0007);
        rd_chk("single_chk_after", CHK, 1'b0, 16'h0000);

        // Fill to full and backpressure.
        base = ack_count;
        for (int i = 1; i <= 9; i++) kp_src.push_back(4'(i));
        wait_acks(base + 8, "fill_acks");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_hold_sod", 16'(kp_statusordata), 16'h0001);
        end
        chk("ninth_not_acked", 16'(ack_count), 16'(base + 8));
        rd_chk("full_chk", CHK, 1'b0, 16'h0083);
        rd_chk("full_pop", DAT, 1'b1, 16'h0001);
        wait_acks(base + 9, "ninth_acked");
        tick();
        for (int v = 2; v <= 9; v++) rd_chk($sformatf("full_drain_%0d", v), DAT, 1'b1, 16'(v));
        rd_chk("full_chk_empty", CHK, 1'b0, 16'h0000);

        // Wrap-around.
        base = ack_count;
        for (int v = 10; v <= 15; v++) kp_src.push_back(4'(v));
        wait_acks(base + 6, "wrap_acks1");
        tick();
        for (int v = 10; v <= 15; v++) rd_chk("wrap_pop1", DAT, 1'b1, 16'(v));
        base = ack_count;
        for (int v = 1; v <= 5; v++) kp_src.push_back(4'(v));
        wait_acks(base + 5, "wrap_acks2");
        tick();
        for (int v = 1; v <= 5; v++) rd_chk("wrap_pop2", DAT, 1'b1, 16'(v));
        rd_chk("wrap_chk_empty", CHK, 1'b0, 16'h0000);

        // Table-driven CPU-side vectors.
        base = ack_count;
        kp_src.push_back(4'h7);
        kp_src.push_back(4'hA);
        wait_acks(base + 2, "tbl_acks");
        tick();
        for (int i = 0; i < 10; i++) begin
            cpu_address = tbl[i].addr;
            cpu_rd      = tbl[i].rd;
            @(negedge CLK); #1;
            chk($sformatf("tbl%0d_hit", i), 16'(cpu_hit), 16'(tbl[i].hit));
            chk($sformatf("tbl%0d_data", i), cpu_rd_data, tbl[i].data);
            tick();
        end
        cpu_rd = 1'b0;

        // Simultaneous push and pop.
        base = ack_count;
        kp_src.push_back(4'hA);
        kp_src.push_back(4'hB);
        kp_src.push_back(4'hC);
        wait_acks(base + 3, "simul_acks");
        kp_src.push_back(4'hD);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (!kp_statusordata && !kp_ack) begin
                found = 1;
                break;
            end
        end
        chk("simul_fetch_seen", 16'(found), 16'h0001);
        cpu_address = DAT;
        cpu_rd      = 1'b1;
        #1;
        chk("simul_old_head", cpu_rd_data, 16'h000A);
        tick();
        cpu_rd      = 1'b0;
        cpu_address = CHK;
        #1;
        chk("simul_count", cpu_rd_data, 16'h0031);
        wait_acks(base + 4, "simul_ack_d");
        tick();
        rd_chk("simul_pop_b", DAT, 1'b1, 16'h000B);
        rd_chk("simul_pop_c", DAT, 1'b1, 16'h000C);
        rd_chk("simul_pop_d", DAT, 1'b1, 16'h000D);

        // Reset in the ACK cycle.
        base = ack_count;
        kp_src.push_back(4'h5);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (kp_ack) begin
                found = 1;
                break;
            end
        end
        chk("rst_ack_seen", 16'(found), 16'h0001);
        rst = 1'b1;
        #1;
        chk("rst_ack_gated", 16'(kp_ack), 16'h0000);
        tick();
        rst = 1'b0;
        cpu_address = CHK;
        #1;
        chk("rst_fifo_empty", cpu_rd_data, 16'h0000);
        chk("rst_key_kept", 16'(ack_count), 16'(base));
        wait_acks(base + 1, "rst_refetch");
        repeat (6) tick();
        chk("rst_single_ack", 16'(ack_count), 16'(base + 1));
        rd_chk("rst_chk", CHK, 1'b0, 16'h0011);
        rd_chk("rst_dat", DAT, 1'b1, 16'h0005);
        rd_chk("rst_chk_empty", CHK, 1'b0, 16'h0000);

        // Randomized traffic against the reference model.
        offered = 0;
        pop0    = n_pop;
        for (int c = 0; c < 1500; c++) begin
            int r;
            if (kp_src.size() < 2 && $urandom_range(0, 2) == 0) begin
                kp_src.push_back(4'($urandom_range(0, 15)));
                offered++;
            end
            r = $urandom_range(0, 3);
            cpu_address = (r == 0) ? CHK : (r == 3) ? 16'($urandom) : DAT;
            if (c < 600) cpu_rd = ($urandom_range(0, 9) == 0);
            else         cpu_rd = ($urandom_range(0, 2) == 0);
            tick();
        end
        cpu_rd = 1'b0;
        k = 0;
        while ((kp_src.size() > 0 || kp_pending) && k < 500) begin
            tick();
            k++;
        end
        cpu_address = DAT;
        cpu_rd      = 1'b1;
        k = 0;
        while ((n_pop - pop0) < offered && k < 200) begin
            tick();
            k++;
        end
        cpu_rd = 1'b0;
        chk("rand_all_keys_delivered", 16'(n_pop - pop0), 16'(offered));
        rd_chk("rand_chk_empty", CHK, 1'b0, 16'h0000);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
